// File: rtl/ql_serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   - State encoding (IDLE/RUN/DONE); encoding 2'd3 is unused and recovers to IDLE.
//   - cnt_w(): bit-counter width, max(1, $clog2(width)).
package ql_serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    // Counter must index 0..width-1 and stay at least one bit wide for width=1.
    function automatic int unsigned cnt_w(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/QL_XOR_MUX2.sv
// Single-bit carry cell: XOR for the sum, 2:1 mux for the carry.
//   p_i      : propagate (a ^ b)
//   g_i      : generate  (a & b)
//   ci_i     : carry in
//   sumout_o : p ^ ci
//   co_o     : p ? ci : g
module QL_XOR_MUX2 (
    input  logic p_i,
    input  logic g_i,
    input  logic ci_i,
    output logic sumout_o,
    output logic co_o
);

    assign sumout_o = p_i ^ ci_i;
    assign co_o     = p_i ? ci_i : g_i;

endmodule

// File: rtl/ql_serial_adder_seq.sv
// Bit-serial add/subtract sequencer. Operands are accepted on a valid/ready handshake,
// processed LSB first through one QL_XOR_MUX2 cell (one bit per clock, carry registered
// between bits) and returned on a second valid/ready handshake.
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   in_valid_i  : a_i/b_i/sub_i valid
//   in_ready_o  : idle, can accept operands
//   a_i, b_i    : WIDTH-bit operands
//   sub_i       : 1 = a-b, 0 = a+b
//   out_valid_o : sum_o/cout_o/ovf_o valid
//   out_ready_i : consumer takes result
//   sum_o       : result modulo 2^WIDTH
//   cout_o      : carry out of MSB (for subtract: 1 = no borrow)
//   ovf_o       : signed overflow
module ql_serial_adder_seq
    import ql_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned     CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_ci_q, ovf_ci_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic accept;
    logic last_bit;
    logic cell_p, cell_g, cell_sum, cell_co;

    assign accept   = in_valid_i && (state_q == StIdle);
    assign last_bit = (cnt_q == CntLast);

    // Carry is fed back through carry_q only, so the cell has no combinational loop.
    assign cell_p = opa_q[0] ^ opb_q[0];
    assign cell_g = opa_q[0] & opb_q[0];

    QL_XOR_MUX2 u_carry_cell (
        .p_i      (cell_p),
        .g_i      (cell_g),
        .ci_i     (carry_q),
        .sumout_o (cell_sum),
        .co_o     (cell_co)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StRun;
            StRun:  if (last_bit) state_d = StDone;
            StDone: if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        sum_o       = sum_q;
        cout_o      = carry_q;
        ovf_o       = ovf_ci_q ^ carry_q;
    end

    // Datapath next-state
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        ovf_ci_d = ovf_ci_q;
        cnt_d    = cnt_q;
        if (accept) begin
            // Subtract as a + ~b + 1: the +1 enters as the initial carry.
            opa_d   = a_i;
            opb_d   = sub_i ? ~b_i : b_i;
            carry_d = sub_i;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            sum_d            = sum_q >> 1;
            sum_d[WIDTH-1]   = cell_sum;
            carry_d          = cell_co;
            opa_d            = opa_q >> 1;
            opb_d            = opb_q >> 1;
            if (last_bit) begin
                ovf_ci_d = carry_q;  // carry into the MSB
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opa_q    <= '0;
            opb_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            ovf_ci_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            ovf_ci_q <= ovf_ci_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ql_serial_adder_seq.sv
module tb_ql_serial_adder_seq;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    ql_serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: full-width add, carry into MSB from the low bits.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic ms,
                         output logic [7:0] esum, output logic ecout, output logic eovf);
        logic [7:0] bb;
        logic [8:0] full;
        logic [7:0] low;
        bb    = ms ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, bb} + {8'd0, ms};
        low   = {1'b0, ma[6:0]} + {1'b0, bb[6:0]} + {7'd0, ms};
        esum  = full[7:0];
        ecout = full[8];
        eovf  = low[7] ^ full[8];
    endtask

    // Present operands for one accept edge; returns #1 after that edge.
    task automatic accept_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                             input string tag);
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb; sub = ~ts;  // must not matter after accept
    endtask

    // Counts edges until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input logic [7:0] esum, input logic ecout, input logic eovf,
                          input string tag);
        int n;
        accept_op(ta, tb, ts, tag);
        wait_done(n);
        check({tag, ".latency"}, 64'(n), 64'd8);
        check({tag, ".sum"}, 64'(sum), 64'(esum));
        check({tag, ".cout"}, 64'(cout), 64'(ecout));
        check({tag, ".ovf"}, 64'(ovf), 64'(eovf));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        int last_acc;
        logic [7:0] ra, rb, esum;
        logic rs, ecout, eovf;
        logic [7:0] hold_sum;
        bit ok;

        // Reset state
        #12;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.sum", 64'(sum), 64'd0);
        check("rst.cout", 64'(cout), 64'd0);
        check("rst.ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

        // Backpressure: result held, new operands refused
        accept_op(8'h33, 8'h44, 1'b0, "bp");
        wait_done(n);
        check("bp.latency", 64'(n), 64'd8);
        hold_sum = sum;
        check("bp.sum0", 64'(hold_sum), 64'h77);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'hAA; b = 8'h11; sub = 1'b1;
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.sum", 64'(sum), 64'h77);
            check("bp.cout_ovf", 64'({cout, ovf}), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.released", 64'(out_valid), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("bp.no_accept_valid", 64'(out_valid), 64'd0);
        check("bp.no_accept_ready", 64'(in_ready), 64'd1);
        check("bp.sum_kept", 64'(sum), 64'h77);

        // Asynchronous reset at RUN bit 3
        accept_op(8'h55, 8'h0F, 1'b0, "arst");
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.in_ready", 64'(in_ready), 64'd1);
        check("arst.sum", 64'(sum), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("arst.no_pulse", 64'(out_valid), 64'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "arst_after");

        // Back-to-back random with IN_VALID/OUT_READY held high
        last_acc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            @(negedge clk);
            a = ra; b = rb; sub = rs; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                check("b2b.ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            if (i > 0) check("b2b.spacing", 64'(edges - last_acc), 64'd10);
            last_acc = edges;
            a = ~ra; b = ~rb;
            wait_done(n);
            model(ra, rb, rs, esum, ecout, eovf);
            check("b2b.latency", 64'(n), 64'd8);
            check("b2b.result", 64'({ecout, eovf, esum} ^ {cout, ovf, sum}), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
